// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Holds the interrupt-sequencer state encoding, the stack page base and the
// hardware vector addresses, plus a helper that forms a stack-page address.
package cpu_pkg;

  localparam logic [15:0] STACK_BASE = 16'h0100;
  localparam logic [15:0] NMI_VEC    = 16'hfffa;
  localparam logic [15:0] RST_VEC    = 16'hfffc;
  localparam logic [15:0] IRQ_VEC    = 16'hfffe;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_PCH = 3'd1,
    PUSH_PCL = 3'd2,
    PUSH_P   = 3'd3,
    VEC_LO   = 3'd4,
    VEC_HI   = 3'd5,
    LOAD     = 3'd6
  } int_state_e;

  // Stack address for the k-th push below sp; the 8-bit offset wraps
  // inside the stack page (8'h00 - 1 = 8'hff).
  function automatic logic [15:0] stack_addr(input logic [15:0] base,
                                             input logic [7:0]  sp_val,
                                             input logic [1:0]  k);
    logic [7:0] off;
    off = sp_val - {6'b0, k};
    return base | {8'h00, off};
  endfunction

endpackage

// File: rtl/int_seq.sv
// int_seq: interrupt / BRK entry sequencer.
// On an instruction boundary with a pending hardware event or a decoded BRK,
// pushes PCH, PCL and P onto the stack page, fetches the 16-bit vector and
// hands it to the PC with one-cycle pc_load / set_i / int_handled pulses.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start, brk          instruction boundary, BRK decoded
//   int_evnt            pending NMI/RST/IRQ
//   int_is_rst          pending event is reset (pushes become dummy reads)
//   int_addr            vector address of the pending event
//   pc, p, sp           current CPU registers
//   rdy, rdata          bus ready and read data
//   bus_addr/wdata/we   bus request
//   sp_dec              decrement sp (one pulse per completed push)
//   pc_load, pc_new     load fetched vector into PC
//   set_i, int_handled  set P.I, acknowledge the interrupt block
//   busy                sequence in progress
//   dbg_state           current FSM state
//
// Handshake: a bus cycle completes on a rising edge where rdy=1; while rdy=0
// the state, bus request and latches hold and no pulse is emitted.
module int_seq #(
  parameter logic [15:0] STACK_BASE = cpu_pkg::STACK_BASE,
  parameter logic [15:0] BRK_VEC    = cpu_pkg::IRQ_VEC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 brk,
  input  logic                 int_evnt,
  input  logic                 int_is_rst,
  input  logic [15:0]          int_addr,
  input  logic [15:0]          pc,
  input  logic [7:0]           p,
  input  logic [7:0]           sp,
  input  logic                 rdy,
  input  logic [7:0]           rdata,
  output logic [15:0]          bus_addr,
  output logic [7:0]           bus_wdata,
  output logic                 bus_we,
  output logic                 sp_dec,
  output logic                 pc_load,
  output logic [15:0]          pc_new,
  output logic                 set_i,
  output logic                 int_handled,
  output logic                 busy,
  output cpu_pkg::int_state_e  dbg_state
);
  import cpu_pkg::*;

  int_state_e  state_q;
  logic [15:0] pc_q;
  logic [7:0]  p_q;
  logic [7:0]  sp_q;
  logic        brk_q;
  logic        rst_q;
  logic [15:0] vec_q;
  logic        vec_valid_q;
  logic        vec_int_q;
  logic [15:0] pc_new_q;
  logic        pc_load_q;
  logic        set_i_q;
  logic        int_handled_q;

  logic [15:0] vec_d;
  logic [7:0]  p_push;

  // The vector is chosen on the first VEC_LO cycle, so an NMI that shows up
  // while the pushes are running can still redirect the sequence.
  assign vec_d  = vec_valid_q ? vec_q : (int_evnt ? int_addr : BRK_VEC);
  assign p_push = {p_q[7:6], 1'b1, brk_q, p_q[3:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      p_q           <= '0;
      sp_q          <= '0;
      brk_q         <= 1'b0;
      rst_q         <= 1'b0;
      vec_q         <= '0;
      vec_valid_q   <= 1'b0;
      vec_int_q     <= 1'b0;
      pc_new_q      <= '0;
      pc_load_q     <= 1'b0;
      set_i_q       <= 1'b0;
      int_handled_q <= 1'b0;
    end else begin
      pc_load_q     <= 1'b0;
      set_i_q       <= 1'b0;
      int_handled_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && (int_evnt || brk)) begin
            pc_q        <= pc;
            p_q         <= p;
            sp_q        <= sp;
            brk_q       <= brk;
            rst_q       <= int_is_rst;
            vec_valid_q <= 1'b0;
            state_q     <= PUSH_PCH;
          end
        end
        PUSH_PCH: if (rdy) state_q <= PUSH_PCL;
        PUSH_PCL: if (rdy) state_q <= PUSH_P;
        PUSH_P:   if (rdy) state_q <= VEC_LO;
        VEC_LO: begin
          if (!vec_valid_q) begin
            vec_q       <= vec_d;
            vec_int_q   <= int_evnt;
            vec_valid_q <= 1'b1;
          end
          if (rdy) begin
            pc_new_q[7:0] <= rdata;
            state_q       <= VEC_HI;
          end
        end
        VEC_HI: begin
          if (rdy) begin
            pc_new_q[15:8] <= rdata;
            pc_load_q      <= 1'b1;
            set_i_q        <= 1'b1;
            int_handled_q  <= vec_int_q;
            state_q        <= LOAD;
          end
        end
        LOAD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus request follows the current state; reset also clears the idle
  // address, which otherwise mirrors pc.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    sp_dec    = 1'b0;
    case (state_q)
      IDLE: bus_addr = reset ? 16'h0000 : pc;
      PUSH_PCH: begin
        bus_addr  = stack_addr(STACK_BASE, sp_q, 2'd0);
        bus_wdata = pc_q[15:8];
        bus_we    = !rst_q;
        sp_dec    = rdy;
      end
      PUSH_PCL: begin
        bus_addr  = stack_addr(STACK_BASE, sp_q, 2'd1);
        bus_wdata = pc_q[7:0];
        bus_we    = !rst_q;
        sp_dec    = rdy;
      end
      PUSH_P: begin
        bus_addr  = stack_addr(STACK_BASE, sp_q, 2'd2);
        bus_wdata = p_push;
        bus_we    = !rst_q;
        sp_dec    = rdy;
      end
      VEC_LO:  bus_addr = vec_d;
      VEC_HI:  bus_addr = vec_q + 16'd1;
      LOAD:    bus_addr = vec_q + 16'd1;
      default: bus_addr = '0;
    endcase
  end

  assign pc_load     = pc_load_q;
  assign set_i       = set_i_q;
  assign int_handled = int_handled_q;
  assign pc_new      = pc_new_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule
